// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and load/store,
// sequencing each access over a req/ack handshake with MEM given priority.
module mem_port_arbiter #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter int unsigned CNT_W       = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            IReqF,
  input  logic [XLEN-1:0] PCF,
  input  logic            HoldF,
  input  logic            FlushD,
  input  logic            DReqM,
  input  logic            MemWriteM,
  input  logic [XLEN-1:0] AddrM,
  input  logic [XLEN-1:0] WriteDataM,
  output logic [XLEN-1:0] InstrF,
  output logic [XLEN-1:0] ReadDataM,
  output logic            StallIF,
  output logic            StallMem,
  output logic            MemReq,
  output logic            MemWe,
  output logic [XLEN-1:0] MemAddr,
  output logic [XLEN-1:0] MemWData,
  input  logic [XLEN-1:0] MemRData,
  input  logic            MemAck,
  output logic            BusErr
);

  localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TIMEOUT_CYC);
  localparam bit               TO_EN  = (TIMEOUT_CYC != 0);

  typedef enum logic [1:0] {IDLE, IBUSY, DBUSY} state_e;

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              drop_q, ivalid_q, dvalid_q;
  logic              req_q, we_q, berr_q;
  logic [XLEN-1:0]   instr_q, rdata_q, addr_q, wdata_q;
  logic              timeout_c, done_c;
  logic [XLEN-1:0]   resp_c;

  // Completion: real ack wins; otherwise a timeout completes with zero data.
  always_comb begin
    cnt_d     = cnt_q + CNT_W'(1);
    timeout_c = TO_EN && (cnt_d == TO_LIM) && !MemAck;
    done_c    = (state_q != IDLE) && (MemAck || timeout_c);
    resp_c    = MemAck ? MemRData : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      drop_q   <= 1'b0;
      ivalid_q <= 1'b0;
      dvalid_q <= 1'b0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      berr_q   <= 1'b0;
      instr_q  <= '0;
      rdata_q  <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      berr_q   <= 1'b0;
      dvalid_q <= 1'b0;
      if (ivalid_q && (!HoldF || FlushD)) ivalid_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (DReqM && !dvalid_q) begin
            state_q <= DBUSY;
            req_q   <= 1'b1;
            we_q    <= MemWriteM;
            addr_q  <= AddrM;
            wdata_q <= WriteDataM;
            cnt_q   <= '0;
          end else if (IReqF && !ivalid_q && !FlushD) begin
            state_q <= IBUSY;
            req_q   <= 1'b1;
            we_q    <= 1'b0;
            addr_q  <= PCF;
            cnt_q   <= '0;
          end
        end
        IBUSY, DBUSY: begin
          if (done_c) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            cnt_q   <= '0;
            berr_q  <= timeout_c;
            if (state_q == DBUSY) begin
              if (!we_q) rdata_q <= resp_c;
              dvalid_q <= 1'b1;
            end else if (drop_q || FlushD) begin
              drop_q <= 1'b0;
            end else begin
              instr_q  <= resp_c;
              ivalid_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_d;
            // A redirect while fetching makes the returning word wrong-path.
            if (state_q == IBUSY && FlushD) drop_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign InstrF    = instr_q;
  assign ReadDataM = rdata_q;
  assign StallIF   = IReqF & ~ivalid_q;
  assign StallMem  = DReqM & ~dvalid_q;
  assign MemReq    = req_q;
  assign MemWe     = we_q;
  assign MemAddr   = addr_q;
  assign MemWData  = wdata_q;
  assign BusErr    = berr_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: cycle vectors for the handshake corner cases,
// then a scoreboarded stream of concurrent loads and fetches against a memory model.
module tb_mem_port_arbiter;

  logic        clk, reset;
  logic        IReqF, HoldF, FlushD, DReqM, MemWriteM, MemAck;
  logic [31:0] PCF, AddrM, WriteDataM, MemRData;
  logic [31:0] InstrF, ReadDataM, MemAddr, MemWData;
  logic        StallIF, StallMem, MemReq, MemWe, BusErr;

  int total = 0;
  int bad   = 0;
  int wcnt  = 0;

  mem_port_arbiter #(.XLEN(32), .TIMEOUT_CYC(4), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .IReqF(IReqF), .PCF(PCF), .HoldF(HoldF), .FlushD(FlushD),
    .DReqM(DReqM), .MemWriteM(MemWriteM), .AddrM(AddrM), .WriteDataM(WriteDataM),
    .InstrF(InstrF), .ReadDataM(ReadDataM), .StallIF(StallIF), .StallMem(StallMem),
    .MemReq(MemReq), .MemWe(MemWe), .MemAddr(MemAddr), .MemWData(MemWData),
    .MemRData(MemRData), .MemAck(MemAck), .BusErr(BusErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  typedef struct {
    string       nm;
    logic        rst, ireq, hold, flush, dreq, we, ack;
    logic [31:0] pc, addr, wd, rd;
    logic        e_req, e_we, e_sif, e_smem, e_berr;
    logic [31:0] e_maddr, e_mwd, e_rdm, e_instr;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] dq[$];
  logic [31:0] iq[$];

  function automatic vec_t mk(string nm, logic rst, logic ireq, logic [31:0] pc, logic hold,
                              logic flush, logic dreq, logic we, logic [31:0] addr,
                              logic [31:0] wd, logic ack, logic [31:0] rd, logic e_req,
                              logic e_we, logic [31:0] e_maddr, logic [31:0] e_mwd,
                              logic e_sif, logic e_smem, logic e_berr, logic [31:0] e_rdm,
                              logic [31:0] e_instr);
    vec_t v;
    v.nm = nm; v.rst = rst; v.ireq = ireq; v.pc = pc; v.hold = hold; v.flush = flush;
    v.dreq = dreq; v.we = we; v.addr = addr; v.wd = wd; v.ack = ack; v.rd = rd;
    v.e_req = e_req; v.e_we = e_we; v.e_maddr = e_maddr; v.e_mwd = e_mwd; v.e_sif = e_sif;
    v.e_smem = e_smem; v.e_berr = e_berr; v.e_rdm = e_rdm; v.e_instr = e_instr;
    return v;
  endfunction

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h13579BDF;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Memory responder: acks after lat request cycles with data from the model.
  task automatic mem_step(input int unsigned lat);
    MemAck = 1'b0;
    if (MemReq) begin
      if (wcnt + 1 >= int'(lat)) begin
        MemAck   = 1'b1;
        MemRData = memf(MemAddr);
        wcnt     = 0;
      end else begin
        wcnt++;
      end
    end else begin
      wcnt = 0;
    end
    @(posedge clk);
    #1;
    MemAck = 1'b0;
  endtask

  initial begin
    // name            rst ireq pc          hold fl dreq we addr         wd     ack rd            | req we maddr      mwd     sif smem berr rdm           instr
    vecs.push_back(mk("ld_req",     0,0,32'h0,  0,0,1,0,32'h40, 32'h0, 0,32'h0,        0,0,32'h0,  32'h0, 0,1,0,32'h0,        32'h0));
    vecs.push_back(mk("ld_busy1",   0,0,32'h0,  0,0,1,0,32'h40, 32'h0, 0,32'h0,        1,0,32'h40, 32'h0, 0,1,0,32'h0,        32'h0));
    vecs.push_back(mk("ld_busy2",   0,0,32'h0,  0,0,1,0,32'h40, 32'h0, 0,32'h0,        1,0,32'h40, 32'h0, 0,1,0,32'h0,        32'h0));
    vecs.push_back(mk("ld_ack",     0,0,32'h0,  0,0,1,0,32'h40, 32'h0, 1,32'hDEADBEEF, 1,0,32'h40, 32'h0, 0,1,0,32'h0,        32'h0));
    vecs.push_back(mk("ld_done",    0,0,32'h0,  0,0,1,0,32'h40, 32'h0, 0,32'h0,        0,0,32'h40, 32'h0, 0,0,0,32'hDEADBEEF, 32'h0));
    vecs.push_back(mk("ld_idle",    0,0,32'h0,  0,0,0,0,32'h0,  32'h0, 0,32'h0,        0,0,32'h40, 32'h0, 0,0,0,32'hDEADBEEF, 32'h0));
    vecs.push_back(mk("st_req",     0,0,32'h0,  0,0,1,1,32'h100,32'h55,0,32'h0,        0,0,32'h40, 32'h0, 0,1,0,32'hDEADBEEF, 32'h0));
    vecs.push_back(mk("st_busy",    0,0,32'h0,  0,0,1,1,32'h100,32'h55,0,32'h0,        1,1,32'h100,32'h55,0,1,0,32'hDEADBEEF, 32'h0));
    vecs.push_back(mk("st_ack",     0,0,32'h0,  0,0,1,1,32'h100,32'h55,1,32'h12345678, 1,1,32'h100,32'h55,0,1,0,32'hDEADBEEF, 32'h0));
    vecs.push_back(mk("st_done",    0,0,32'h0,  0,0,1,1,32'h100,32'h55,0,32'h0,        0,0,32'h100,32'h55,0,0,0,32'hDEADBEEF, 32'h0));
    vecs.push_back(mk("st_idle",    0,0,32'h0,  0,0,0,0,32'h0,  32'h0, 0,32'h0,        0,0,32'h100,32'h55,0,0,0,32'hDEADBEEF, 32'h0));
    vecs.push_back(mk("both_req",   0,1,32'h200,0,0,1,0,32'h44, 32'h0, 0,32'h0,        0,0,32'h100,32'h55,1,1,0,32'hDEADBEEF, 32'h0));
    vecs.push_back(mk("both_dbusy", 0,1,32'h200,0,0,1,0,32'h44, 32'h0, 0,32'h0,        1,0,32'h44, 32'h0, 1,1,0,32'hDEADBEEF, 32'h0));
    vecs.push_back(mk("both_dack",  0,1,32'h200,0,0,1,0,32'h44, 32'h0, 1,32'hAAAA5555, 1,0,32'h44, 32'h0, 1,1,0,32'hDEADBEEF, 32'h0));
    vecs.push_back(mk("both_ddone", 0,1,32'h200,0,0,1,0,32'h44, 32'h0, 0,32'h0,        0,0,32'h44, 32'h0, 1,0,0,32'hAAAA5555, 32'h0));
    vecs.push_back(mk("both_ibusy", 0,1,32'h200,0,0,0,0,32'h0,  32'h0, 0,32'h0,        1,0,32'h200,32'h0, 1,0,0,32'hAAAA5555, 32'h0));
    vecs.push_back(mk("both_iack",  0,1,32'h200,0,0,0,0,32'h0,  32'h0, 1,32'h00500093, 1,0,32'h200,32'h0, 1,0,0,32'hAAAA5555, 32'h0));
    vecs.push_back(mk("both_idone", 0,1,32'h200,0,0,0,0,32'h0,  32'h0, 0,32'h0,        0,0,32'h200,32'h0, 0,0,0,32'hAAAA5555, 32'h00500093));
    vecs.push_back(mk("if_idle",    0,0,32'h0,  0,0,0,0,32'h0,  32'h0, 0,32'h0,        0,0,32'h200,32'h0, 0,0,0,32'hAAAA5555, 32'h00500093));
    vecs.push_back(mk("fl_req",     0,1,32'h300,0,0,0,0,32'h0,  32'h0, 0,32'h0,        0,0,32'h200,32'h0, 1,0,0,32'hAAAA5555, 32'h00500093));
    vecs.push_back(mk("fl_flush",   0,1,32'h300,0,1,0,0,32'h0,  32'h0, 0,32'h0,        1,0,32'h300,32'h0, 1,0,0,32'hAAAA5555, 32'h00500093));
    vecs.push_back(mk("fl_busy",    0,1,32'h400,0,0,0,0,32'h0,  32'h0, 0,32'h0,        1,0,32'h300,32'h0, 1,0,0,32'hAAAA5555, 32'h00500093));
    vecs.push_back(mk("fl_ack",     0,1,32'h400,0,0,0,0,32'h0,  32'h0, 1,32'h00000013, 1,0,32'h300,32'h0, 1,0,0,32'hAAAA5555, 32'h00500093));
    vecs.push_back(mk("fl_drop",    0,1,32'h400,0,0,0,0,32'h0,  32'h0, 0,32'h0,        0,0,32'h300,32'h0, 1,0,0,32'hAAAA5555, 32'h00500093));
    vecs.push_back(mk("fl_refetch", 0,1,32'h400,0,0,0,0,32'h0,  32'h0, 0,32'h0,        1,0,32'h400,32'h0, 1,0,0,32'hAAAA5555, 32'h00500093));
    vecs.push_back(mk("fl_reack",   0,1,32'h400,0,0,0,0,32'h0,  32'h0, 1,32'h00A00113, 1,0,32'h400,32'h0, 1,0,0,32'hAAAA5555, 32'h00500093));
    vecs.push_back(mk("hold1",      0,1,32'h400,1,0,0,0,32'h0,  32'h0, 0,32'h0,        0,0,32'h400,32'h0, 0,0,0,32'hAAAA5555, 32'h00A00113));
    vecs.push_back(mk("hold2",      0,1,32'h400,1,0,0,0,32'h0,  32'h0, 0,32'h0,        0,0,32'h400,32'h0, 0,0,0,32'hAAAA5555, 32'h00A00113));
    vecs.push_back(mk("hold_rel",   0,1,32'h400,0,0,0,0,32'h0,  32'h0, 0,32'h0,        0,0,32'h400,32'h0, 0,0,0,32'hAAAA5555, 32'h00A00113));
    vecs.push_back(mk("hold_clr",   0,1,32'h404,0,1,0,0,32'h0,  32'h0, 0,32'h0,        0,0,32'h400,32'h0, 1,0,0,32'hAAAA5555, 32'h00A00113));
    vecs.push_back(mk("fl_noissue", 0,0,32'h0,  0,0,0,0,32'h0,  32'h0, 0,32'h0,        0,0,32'h400,32'h0, 0,0,0,32'hAAAA5555, 32'h00A00113));
    vecs.push_back(mk("to_req",     0,0,32'h0,  0,0,1,0,32'h80, 32'h0, 0,32'h0,        0,0,32'h400,32'h0, 0,1,0,32'hAAAA5555, 32'h00A00113));
    vecs.push_back(mk("to_b1",      0,0,32'h0,  0,0,1,0,32'h80, 32'h0, 0,32'h0,        1,0,32'h80, 32'h0, 0,1,0,32'hAAAA5555, 32'h00A00113));
    vecs.push_back(mk("to_b2",      0,0,32'h0,  0,0,1,0,32'h80, 32'h0, 0,32'h0,        1,0,32'h80, 32'h0, 0,1,0,32'hAAAA5555, 32'h00A00113));
    vecs.push_back(mk("to_b3",      0,0,32'h0,  0,0,1,0,32'h80, 32'h0, 0,32'h0,        1,0,32'h80, 32'h0, 0,1,0,32'hAAAA5555, 32'h00A00113));
    vecs.push_back(mk("to_b4",      0,0,32'h0,  0,0,1,0,32'h80, 32'h0, 0,32'h0,        1,0,32'h80, 32'h0, 0,1,0,32'hAAAA5555, 32'h00A00113));
    vecs.push_back(mk("to_err",     0,0,32'h0,  0,0,1,0,32'h80, 32'h0, 0,32'h0,        0,0,32'h80, 32'h0, 0,0,1,32'h0,        32'h00A00113));
    vecs.push_back(mk("to_stray",   0,0,32'h0,  0,0,0,0,32'h0,  32'h0, 1,32'h77777777, 0,0,32'h80, 32'h0, 0,0,0,32'h0,        32'h00A00113));
    vecs.push_back(mk("to_idle",    0,0,32'h0,  0,0,0,0,32'h0,  32'h0, 0,32'h0,        0,0,32'h80, 32'h0, 0,0,0,32'h0,        32'h00A00113));
    vecs.push_back(mk("rs_req",     0,0,32'h0,  0,0,1,0,32'h88, 32'h0, 0,32'h0,        0,0,32'h80, 32'h0, 0,1,0,32'h0,        32'h00A00113));
    vecs.push_back(mk("rs_rst",     1,0,32'h0,  0,0,1,0,32'h88, 32'h0, 0,32'h0,        1,0,32'h88, 32'h0, 0,1,0,32'h0,        32'h00A00113));
    vecs.push_back(mk("rs_ack",     0,0,32'h0,  0,0,0,0,32'h0,  32'h0, 1,32'hCAFEF00D, 0,0,32'h0,  32'h0, 0,0,0,32'h0,        32'h0));
    vecs.push_back(mk("rs_idle",    0,0,32'h0,  0,0,0,0,32'h0,  32'h0, 0,32'h0,        0,0,32'h0,  32'h0, 0,0,0,32'h0,        32'h0));

    reset = 1'b1; IReqF = 1'b0; PCF = '0; HoldF = 1'b0; FlushD = 1'b0; DReqM = 1'b0;
    MemWriteM = 1'b0; AddrM = '0; WriteDataM = '0; MemRData = '0; MemAck = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("rst.MemReq",    32'(MemReq),   32'h0);
    chk("rst.MemWe",     32'(MemWe),    32'h0);
    chk("rst.MemAddr",   MemAddr,       32'h0);
    chk("rst.MemWData",  MemWData,      32'h0);
    chk("rst.InstrF",    InstrF,        32'h0);
    chk("rst.ReadDataM", ReadDataM,     32'h0);
    chk("rst.BusErr",    32'(BusErr),   32'h0);

    // Ack while IDLE right after reset must be ignored.
    MemAck = 1'b1; MemRData = 32'hBADBAD00;
    @(posedge clk);
    #1;
    MemAck = 1'b0;
    #1;
    chk("idle_ack.MemReq",    32'(MemReq), 32'h0);
    chk("idle_ack.ReadDataM", ReadDataM,   32'h0);
    chk("idle_ack.InstrF",    InstrF,      32'h0);

    foreach (vecs[i]) begin
      reset = vecs[i].rst; IReqF = vecs[i].ireq; PCF = vecs[i].pc; HoldF = vecs[i].hold;
      FlushD = vecs[i].flush; DReqM = vecs[i].dreq; MemWriteM = vecs[i].we;
      AddrM = vecs[i].addr; WriteDataM = vecs[i].wd; MemAck = vecs[i].ack; MemRData = vecs[i].rd;
      #1;
      chk($sformatf("%s.MemReq", vecs[i].nm),    32'(MemReq),   32'(vecs[i].e_req));
      chk($sformatf("%s.MemWe", vecs[i].nm),     32'(MemWe),    32'(vecs[i].e_we));
      chk($sformatf("%s.MemAddr", vecs[i].nm),   MemAddr,       vecs[i].e_maddr);
      chk($sformatf("%s.MemWData", vecs[i].nm),  MemWData,      vecs[i].e_mwd);
      chk($sformatf("%s.StallIF", vecs[i].nm),   32'(StallIF),  32'(vecs[i].e_sif));
      chk($sformatf("%s.StallMem", vecs[i].nm),  32'(StallMem), 32'(vecs[i].e_smem));
      chk($sformatf("%s.BusErr", vecs[i].nm),    32'(BusErr),   32'(vecs[i].e_berr));
      chk($sformatf("%s.ReadDataM", vecs[i].nm), ReadDataM,     vecs[i].e_rdm);
      chk($sformatf("%s.InstrF", vecs[i].nm),    InstrF,        vecs[i].e_instr);
      @(posedge clk);
      #1;
    end

    reset = 1'b0; IReqF = 1'b0; HoldF = 1'b0; FlushD = 1'b0; DReqM = 1'b0; MemWriteM = 1'b0;
    MemAck = 1'b0; wcnt = 0;

    // Concurrent load/fetch traffic; expectations queued at issue, checked at completion.
    for (int j = 0; j < 12; j++) begin
      bit          dpend, ipend;
      int unsigned budget, lat;
      logic [31:0] a, p;
      a = 32'h2000 + 32'($urandom_range(0, 255)) * 32'd4;
      p = 32'h8000 + 32'(j) * 32'd4;
      lat = $urandom_range(1, 3);
      dpend = (j % 3 != 2);
      ipend = 1'b1;
      if (dpend) begin
        DReqM = 1'b1; AddrM = a; MemWriteM = 1'b0;
        dq.push_back(memf(a));
      end
      IReqF = 1'b1; PCF = p;
      iq.push_back(memf(p));
      budget = 0;
      while ((dpend || ipend) && budget < 40) begin
        #1;
        if (dpend && !StallMem) begin
          chk($sformatf("sb_load%0d", j), ReadDataM, dq.pop_front());
          dpend = 1'b0;
          DReqM = 1'b0;
        end
        if (ipend && !StallIF) begin
          chk($sformatf("sb_fetch%0d", j), InstrF, iq.pop_front());
          ipend = 1'b0;
          IReqF = 1'b0;
        end
        mem_step(lat);
        budget++;
      end
      if (dpend || ipend) begin
        total++;
        bad++;
        $display("FAIL sb_wait%0d: got pending d=%0d i=%0d want none", j, dpend, ipend);
        DReqM = 1'b0; IReqF = 1'b0;
      end
      mem_step(lat);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
